// File: rtl/reg_file_16.sv
// rtl/reg_file_16.sv - 8x16 register file with registered dual read ports and one write port.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data to a colliding read port.
module reg_file_16 #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    output logic              rd_valid
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data1;
    logic [WIDTH-1:0] r_rd_data2;
    logic             r_rd_valid;
    logic [WIDTH-1:0] w_rd_next1;
    logic [WIDTH-1:0] w_rd_next2;

`ifdef REGFILE_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    // Forwarding is per port: each port independently picks the incoming write data.
    assign w_hit1     = wr_en && (wr_addr == rd_addr1);
    assign w_hit2     = wr_en && (wr_addr == rd_addr2);
    assign w_rd_next1 = w_hit1 ? wr_data : r_mem[rd_addr1];
    assign w_rd_next2 = w_hit2 ? wr_data : r_mem[rd_addr2];
`else
    // Array is sampled before this edge's write lands, so collisions return old contents.
    assign w_rd_next1 = r_mem[rd_addr1];
    assign w_rd_next2 = r_mem[rd_addr2];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '{default: '0};
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Operands hold when idle so the downstream adder input stays stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data1 <= w_rd_next1;
                r_rd_data2 <= w_rd_next2;
            end
        end
    end

    assign rd_data1 = r_rd_data1;
    assign rd_data2 = r_rd_data2;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_reg_file_16.sv
// tb/tb_reg_file_16.sv - self-checking bench for reg_file_16 with an array-based reference model.
module tb_reg_file_16;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic        rd_valid;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 0;

    logic [15:0] m_mem [8] = '{default: 16'h0000};
    logic [15:0] e_d1 = 16'h0000;
    logic [15:0] e_d2 = 16'h0000;
    logic        e_v  = 1'b0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file_16 dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each edge reads the array as it stood, then applies the write.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mem <= '{default: 16'h0000};
            e_d1  <= 16'h0000;
            e_d2  <= 16'h0000;
            e_v   <= 1'b0;
        end else begin
            e_v <= rd_en;
            if (rd_en) begin
                e_d1 <= (BYPASS && wr_en && wr_addr == rd_addr1) ? wr_data : m_mem[rd_addr1];
                e_d2 <= (BYPASS && wr_en && wr_addr == rd_addr2) ? wr_data : m_mem[rd_addr2];
            end
            if (wr_en) m_mem[wr_addr] <= wr_data;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_rd_valid", {15'd0, rd_valid}, {15'd0, e_v});
            chk("model_rd_data1", rd_data1, e_d1);
            chk("model_rd_data2", rd_data2, e_d2);
        end
    end

    // Drives one edge's worth of inputs and returns at the following negedge.
    task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic re, input logic [2:0] a1, input logic [2:0] a2);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr1 = a1; rd_addr2 = a2;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0);
    endtask

    logic [15:0] sum;
    logic [15:0] hold1;
    logic [15:0] hold2;

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_rd_data1", rd_data1, 16'h0000);
        chk("reset_rd_data2", rd_data2, 16'h0000);
        chk("reset_rd_valid", {15'd0, rd_valid}, 16'h0000);
        reset_n = 1'b1;
        idle();

        step(1'b1, 3'd2, 16'd10, 1'b0, 3'd0, 3'd0);
        step(1'b1, 3'd5, 16'd2, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd5);
        chk("wr_rd_data1", rd_data1, 16'd10);
        chk("wr_rd_data2", rd_data2, 16'd2);
        chk("wr_rd_valid", {15'd0, rd_valid}, 16'd1);

        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2);
        sum = rd_data1 + rd_data2;
        chk("adder_sum_20", sum, 16'd20);
        step(1'b1, 3'd7, sum, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd7);
        chk("loop_r7_p1", rd_data1, 16'd20);
        chk("loop_r7_p2", rd_data2, 16'd20);
        sum = rd_data1 + rd_data2;
        chk("adder_sum_40", sum, 16'd40);

        step(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0);
        chk("wrap_r0_p1", rd_data1, 16'hFFFF);
        chk("wrap_r0_p2", rd_data2, 16'hFFFF);
        sum = rd_data1 + rd_data2;
        chk("wrap_sum", sum, 16'hFFFE);
        step(1'b1, 3'd1, sum, 1'b0, 3'd0, 3'd0);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1);
        chk("wrap_r1", rd_data1, 16'hFFFE);

        step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0);
        step(1'b1, 3'd3, 16'hABCD, 1'b1, 3'd3, 3'd5);
`ifdef REGFILE_BYPASS_EN
        chk("collide_p1", rd_data1, 16'hABCD);
`else
        chk("collide_p1", rd_data1, 16'h1234);
`endif
        chk("collide_p2_indep", rd_data2, 16'd2);
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd3);
        chk("collide_next", rd_data1, 16'hABCD);

        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd5);
        chk("hold_pulse_valid", {15'd0, rd_valid}, 16'd1);
        hold1 = 16'd10;
        hold2 = 16'd2;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, (k == 1) ? 3'd5 : 3'd2, 16'h5A00 + 16'(k), 1'b0, 3'd2, 3'd5);
            chk("hold_valid_low", {15'd0, rd_valid}, 16'd0);
            chk("hold_data1", rd_data1, hold1);
            chk("hold_data2", rd_data2, hold2);
        end

        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_d1", rd_data1, 16'h0000);
        chk("async_rst_d2", rd_data2, 16'h0000);
        chk("async_rst_valid", {15'd0, rd_valid}, 16'd0);
        step(1'b1, 3'd7, 16'h7777, 1'b1, 3'd7, 3'd7);
        chk("rst_wins_valid", {15'd0, rd_valid}, 16'd0);
        reset_n = 1'b1;
        step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd2);
        chk("post_rst_r7", rd_data1, 16'h0000);
        chk("post_rst_r2", rd_data2, 16'h0000);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            step($urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                 $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7)));
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_16.md
Name: reg_file_16

Overview:
- 8-entry x 16-bit register file. It is the operand-source and write-back stage around the 16-bit adder.
- Read ports 1/2 drive the adder's in1/in2 directly.
- The write port captures the adder's out.
- Reads are registered: one-cycle read latency with a valid strobe, so the downstream combinational adder sees stable operands for a full cycle.

Parameters:
- WIDTH, 16, data width of each register and of all data ports
- DEPTH, 8, number of registers; power of two only
- ADDR_W, 3, address width; must equal log2(DEPTH)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- wr_en  input  1  write strobe, sampled at rising edge of clk
- wr_addr  input  ADDR_W  destination register index
- wr_data  input  WIDTH  write data (adder out)
- rd_en  input  1  read request, sampled at rising edge of clk
- rd_addr1  input  ADDR_W  source index for port 1
- rd_addr2  input  ADDR_W  source index for port 2
- rd_data1  output  WIDTH  registered operand 1 (to adder in1)
- rd_data2  output  WIDTH  registered operand 2 (to adder in2)
- rd_valid  output  1  high for exactly the cycle after an accepted read

Behaviour:
- Reset: reset_n low asynchronously clears all DEPTH registers to 0, rd_data1=0, rd_data2=0, rd_valid=0, regardless of clk.
- Reset mid-operation: reset_n asserted in the same cycle as wr_en or rd_en wins. No write lands, rd_valid stays 0. First edge with reset_n high operates normally.
- Write: at a rising edge with wr_en=1, mem[wr_addr] <= wr_data. wr_en=0 leaves the array unchanged. Full WIDTH is stored with no truncation or sign handling.
- Read: at a rising edge with rd_en=1:
  - rd_data1 <= mem[rd_addr1], rd_data2 <= mem[rd_addr2]
  - rd_valid <= 1
  - Latency is 1 cycle from request edge to data.
- Idle read: rd_en=0 at an edge gives rd_valid <= 0. rd_data1/rd_data2 hold their last values and are not cleared.
- Same address on both read ports is legal; both outputs carry the same value.
- Back-to-back reads on consecutive edges give rd_valid high continuously, with data updated every cycle.
- Simultaneous write and read of the same address at one edge: read-before-write, so the read returns the old contents. The new value is visible to a read on the following edge. Overridden by the optional feature below.
- Simultaneous write and read of different addresses are independent.
- All addresses are in range because DEPTH = 2^ADDR_W. No error handling is required.
- No X propagation: outputs are defined from reset onward.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- When defined, a write-to-read bypass applies. If wr_en=1 and rd_en=1 at the same edge and rd_addrN == wr_addr, then rd_dataN <= wr_data (the new value) for that port only. The array is still written.
- When not defined, read-before-write semantics as above: the read returns the old value.
- The bypass is per port and independent; both ports may bypass in the same cycle.

Test Plan:
- Reset: drive reset_n=0 mid-cycle after the array was written -> rd_data1=rd_data2=0 and rd_valid=0 immediately. A later read of any address returns 16'h0000.
- Write then read: write r2=16'd10, r5=16'd2, then read rd_addr1=2, rd_addr2=5 -> next cycle rd_data1=16'd10, rd_data2=16'd2, rd_valid=1.
- Adder loop: adder out (10+10=20) written to r7, then r7 read on both ports -> rd_data1=rd_data2=16'd20. Adder out is 16'd40 the following cycle.
- Wrap value: write r0=16'hFFFF, read r0 on both ports -> 16'hFFFF on both. Adder out wraps to 16'hFFFE, write it back to r1 -> r1 reads 16'hFFFE.
- Collision at one edge: r3 holds 16'h1234; in the same edge write r3=16'hABCD and read r3 on port 1:
  - Without REGFILE_BYPASS_EN -> rd_data1=16'h1234, and the next read returns 16'hABCD.
  - With REGFILE_BYPASS_EN -> rd_data1=16'hABCD.
- Hold/valid: rd_en pulsed for one cycle then low for 3 cycles -> rd_valid is 1 for exactly one cycle, then 0. rd_data1/rd_data2 unchanged over those 3 cycles even if r-values are rewritten.
